// File: rtl/adventure_fsm.sv
// adventure_fsm
//
// Room-navigation state machine for the adventure game. Produces the 9-bit
// digit_data word consumed by game_display.
//
// Four debounced (but clock-asynchronous) direction buttons are synchronized,
// edge-detected and turned into single moves. The block tracks the current
// room, sword possession and the accepted-move count, and resolves the dragon
// encounter after a fixed hold in the Dragon's Den.
//
// The FSM state is the one-hot room register itself. It is visible on
// digit_data[6:0], so checkers can bind to it directly.
//
// Optional feature: define MOVE_LIMIT_EN to enable the move budget. When the
// accepted move that brings move_count to MAX_MOVES does not enter DEN, the
// player lands in GRAVE instead. A move into DEN on the limit proceeds
// normally.
//
// Parameters:
//   DEN_HOLD   cycles DEN is shown before the fight resolves (>= 1)
//   MAX_MOVES  move budget, used only with MOVE_LIMIT_EN (1..255)
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   btn_n/s/e/w in   debounced direction buttons, asynchronous to clk
//   digit_data  out  [6:0] one-hot room, [7] sword held, [8] game over
//   move_count  out  accepted moves since reset, saturating at 255
module adventure_fsm #(
  parameter int DEN_HOLD  = 4,
  parameter int MAX_MOVES = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_n,
  input  logic       btn_s,
  input  logic       btn_e,
  input  logic       btn_w,
  output logic [8:0] digit_data,
  output logic [7:0] move_count
);

  localparam logic [6:0] ROOM_CAVE    = 7'b000_0001;
  localparam logic [6:0] ROOM_TUNNEL  = 7'b000_0010;
  localparam logic [6:0] ROOM_RIVER   = 7'b000_0100;
  localparam logic [6:0] ROOM_STASH   = 7'b000_1000;
  localparam logic [6:0] ROOM_DEN     = 7'b001_0000;
  localparam logic [6:0] ROOM_VICTORY = 7'b010_0000;
  localparam logic [6:0] ROOM_GRAVE   = 7'b100_0000;

  localparam int HW = (DEN_HOLD > 1) ? $clog2(DEN_HOLD) : 1;

  generate
    if (DEN_HOLD < 1 || MAX_MOVES < 1 || MAX_MOVES > 255) begin : g_bad_param
      $error("adventure_fsm: DEN_HOLD must be >= 1 and MAX_MOVES in 1..255");
    end
  endgenerate

  // Button vector order: {n, s, e, w}.
  logic [3:0]    btn_raw;
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    prev_q;
  logic [1:0]    warm_q;
  logic [3:0]    edges;

  logic [6:0]    room_q;
  logic          sword_q;
  logic          over_q;
  logic [HW-1:0] hold_q;
  logic [7:0]    count_q;

  logic          dir_n, dir_s, dir_e, dir_w;
  logic [6:0]    dest;
  logic          accepted;
  logic [6:0]    room_nxt;
  logic          sword_nxt;
  logic          over_nxt;
  logic [HW-1:0] hold_nxt;
  logic [7:0]    count_nxt;

  assign btn_raw = {btn_n, btn_s, btn_e, btn_w};

  // Edges are ignored until prev_q holds a value that was actually sampled
  // after reset release (three cycles). A button held through reset therefore
  // never counts as a fresh press.
  assign edges = sync2_q & ~prev_q & {4{warm_q == 2'd3}};

  always_comb begin
    dir_n = 1'b0;
    dir_s = 1'b0;
    dir_e = 1'b0;
    dir_w = 1'b0;
    // Only a single edge is a move request; coincident edges are discarded.
    case (edges)
      4'b1000: dir_n = 1'b1;
      4'b0100: dir_s = 1'b1;
      4'b0010: dir_e = 1'b1;
      4'b0001: dir_w = 1'b1;
      default: ;
    endcase
  end

  // Room map. DEN and the terminal rooms never decode a move, so dest
  // differs from room_q exactly when a legal move is requested.
  always_comb begin
    dest = room_q;
    case (room_q)
      ROOM_CAVE: begin
        if (dir_e) dest = ROOM_TUNNEL;
      end
      ROOM_TUNNEL: begin
        if (dir_w)      dest = ROOM_CAVE;
        else if (dir_s) dest = ROOM_RIVER;
      end
      ROOM_RIVER: begin
        if (dir_n)      dest = ROOM_TUNNEL;
        else if (dir_w) dest = ROOM_STASH;
        else if (dir_e) dest = ROOM_DEN;
      end
      ROOM_STASH: begin
        if (dir_e) dest = ROOM_RIVER;
      end
      default: dest = room_q;
    endcase
  end

  assign accepted = (dest != room_q);

  always_comb begin
    room_nxt  = room_q;
    hold_nxt  = hold_q;
    count_nxt = count_q;

    if (accepted) begin
      room_nxt  = dest;
      count_nxt = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
`ifdef MOVE_LIMIT_EN
      // The move that spends the last unit of budget ends the game unless it
      // is the step into the Den.
      if (({1'b0, count_q} + 9'd1 == 9'(MAX_MOVES)) && (dest != ROOM_DEN)) begin
        room_nxt = ROOM_GRAVE;
      end
`endif
      if (room_nxt == ROOM_DEN) begin
        hold_nxt = HW'(DEN_HOLD - 1);
      end
    end

    // The hold counter starts at DEN_HOLD-1 on entry and the exit is taken
    // on the cycle it reads 0, giving exactly DEN_HOLD cycles in DEN.
    if (room_q == ROOM_DEN) begin
      if (hold_q == '0) begin
        room_nxt = sword_q ? ROOM_VICTORY : ROOM_GRAVE;
      end else begin
        hold_nxt = hold_q - 1'b1;
      end
    end

    sword_nxt = sword_q | (room_nxt == ROOM_STASH);
    over_nxt  = (room_nxt == ROOM_VICTORY) || (room_nxt == ROOM_GRAVE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
      room_q  <= ROOM_CAVE;
      sword_q <= 1'b0;
      over_q  <= 1'b0;
      hold_q  <= '0;
      count_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
      room_q  <= room_nxt;
      sword_q <= sword_nxt;
      over_q  <= over_nxt;
      hold_q  <= hold_nxt;
      count_q <= count_nxt;
    end
  end

  assign digit_data = {over_q, sword_q, room_q};
  assign move_count = count_q;

endmodule
